// File: rtl/pcs_pkg.sv
// -----------------------------------------------------------------------------
// pcs_pkg
// Shared 1000BASE-T PCS definitions used by both the transmit Encoder and the
// receive decoder:
//   - pcs_rx_state_e : receive decoder FSM states
//   - SSD1/SSD2/ESD1/ESD2 : frame delimiter quartets {A,B,C,D}
//   - LFSR_W, TAP_MASTER, TAP_SLAVE : side-stream scrambler polynomial taps
//   - sym_valid / sym_is_pm2 / sym_bits : per-symbol helpers
//   - sym_to_sd : quartet -> 8 recovered code bits
//   - scr_to_sd : predicted scrambler state -> 8 expected code bits
// Symbols are 3-bit two's complement: -2=110 -1=111 0=000 +1=001 +2=010.
// -----------------------------------------------------------------------------
package pcs_pkg;

  typedef enum logic [2:0] {
    ST_UNLOCKED = 3'd0,
    ST_CHECK    = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SSD2     = 3'd3,
    ST_DATA     = 3'd4,
    ST_ESD2     = 3'd5
  } pcs_rx_state_e;

  localparam logic [2:0]  SYM_P2 = 3'b010;
  localparam logic [2:0]  SYM_M2 = 3'b110;

  localparam logic [11:0] SSD1 = {SYM_P2, SYM_P2, SYM_P2, SYM_P2};
  localparam logic [11:0] SSD2 = {SYM_P2, SYM_P2, SYM_P2, SYM_M2};
  localparam logic [11:0] ESD1 = SSD1;
  localparam logic [11:0] ESD2 = SSD2;

  // x^33 + x^13 + 1 (master) / x^33 + x^20 + 1 (slave); bit k of the shift
  // register holds the sample taken k+1 cycles ago.
  localparam int LFSR_W     = 33;
  localparam int TAP_MASTER = 12;
  localparam int TAP_SLAVE  = 19;

  // -3, -4 and +3 are not PAM5 levels.
  function automatic logic sym_valid(input logic [2:0] s);
    logic v;
    case (s)
      3'b011, 3'b100, 3'b101: v = 1'b0;
      default:                v = 1'b1;
    endcase
    return v;
  endfunction

  function automatic logic sym_is_pm2(input logic [2:0] s);
    return (s == SYM_P2) || (s == SYM_M2);
  endfunction

  // Data levels carry two code bits each; +2 only appears in delimiters.
  function automatic logic [1:0] sym_bits(input logic [2:0] s);
    logic [1:0] b;
    case (s)
      3'b001:  b = 2'b01;
      3'b111:  b = 2'b10;
      3'b110:  b = 2'b11;
      default: b = 2'b00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] sym_to_sd(input logic [2:0] a, input logic [2:0] b,
                                           input logic [2:0] c, input logic [2:0] d);
    return {sym_bits(a), sym_bits(b), sym_bits(c), sym_bits(d)};
  endfunction

  // Bit 0 is the newest scrambler bit, so it is what idle symbols carry.
  function automatic logic [7:0] scr_to_sd(input logic [LFSR_W-1:0] s);
    return {s[7:1] ^ s[20:14], s[0]};
  endfunction

endpackage

// File: rtl/pcs_rx_descrambler.sv
// -----------------------------------------------------------------------------
// pcs_rx_descrambler
// 33-bit side-stream LFSR for the receive path.
//   clock, reset : clock and synchronous active-high reset (LFSR cleared)
//   i_load       : shift i_load_bit in (acquisition from the idle stream)
//   i_load_bit   : recovered scrambler bit to shift in
//   i_advance    : free-run one step using the polynomial feedback
//   o_pred       : state after the next step, i.e. the prediction for the
//                  quartet currently on the input
// Parameter MASTER: 1 selects x^33+x^13+1, 0 selects x^33+x^20+1.
// -----------------------------------------------------------------------------
module pcs_rx_descrambler
  import pcs_pkg::*;
#(
  parameter int MASTER = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_load_bit,
  input  logic              i_advance,
  output logic [LFSR_W-1:0] o_pred
);

  localparam int TAP = (MASTER != 0) ? TAP_MASTER : TAP_SLAVE;

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb   = r_lfsr[LFSR_W-1] ^ r_lfsr[TAP];
  assign o_pred = {r_lfsr[LFSR_W-2:0], w_fb};

  // Shift register: load has priority over free-running advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= '0;
    end else if (i_load) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], i_load_bit};
    end else if (i_advance) begin
      r_lfsr <= o_pred;
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

endmodule

// File: rtl/pcs_rx_decoder.sv
// -----------------------------------------------------------------------------
// pcs_rx_decoder
// 1000BASE-T PCS receive decoder: synchronises the side-stream descrambler
// from idle, tracks SSD/ESD delimiters and recovers frame bytes.
//   clock       : sole clock
//   reset       : synchronous, active-high
//   io_rxData   : quartet A[11:9] B[8:6] C[5:3] D[2:0]
//   io_rxValid  : quartet qualifier; state and LFSR advance only when high
//   io_rxByte   : recovered byte (holds when nothing new is produced)
//   io_rxDv     : io_rxByte is frame data
//   io_rxEr     : receive error this cycle
//   io_locked   : descrambler synchronised
//   io_errCount : saturating count of io_rxEr cycles (only when the
//                 PCS_RX_ERR_COUNT_EN macro is defined)
// All outputs are registered: one cycle of latency from the sampled quartet.
// -----------------------------------------------------------------------------
module pcs_rx_decoder
  import pcs_pkg::*;
#(
  parameter int MASTER      = 1,
  parameter int LOCK_CHECK  = 16,
  parameter int UNLOCK_MISS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] io_rxData,
  input  logic        io_rxValid,
  output logic [7:0]  io_rxByte,
  output logic        io_rxDv,
  output logic        io_rxEr,
  output logic        io_locked
`ifdef PCS_RX_ERR_COUNT_EN
  ,
  output logic [15:0] io_errCount
`endif
);

  localparam logic [15:0] LOAD_LAST    = 16'd32;
  localparam logic [15:0] LOCK_CHECK_C = 16'(LOCK_CHECK);
  localparam logic [15:0] MISS_LAST    = 16'(UNLOCK_MISS - 1);

  pcs_rx_state_e     r_state, w_state_nx;
  logic [15:0]       r_cnt, w_cnt_nx;
  logic [15:0]       r_miss, w_miss_nx;
  logic [7:0]        r_byte, w_byte_nx;
  logic              r_dv, w_dv_nx;
  logic              r_er, w_er_nx;
  logic              r_locked, w_locked_nx;
  logic              w_load, w_adv;
  logic [LFSR_W-1:0] w_pred;
  logic [7:0]        w_sd_rx, w_sd_exp;
  logic              w_all_valid, w_all_pm2, w_is_dlm1, w_is_dlm2, w_match;

  pcs_rx_descrambler #(.MASTER(MASTER)) u_descr (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_bit (w_sd_rx[0]),
    .i_advance  (w_adv),
    .o_pred     (w_pred)
  );

  assign w_sd_rx     = sym_to_sd(io_rxData[11:9], io_rxData[8:6], io_rxData[5:3], io_rxData[2:0]);
  assign w_sd_exp    = scr_to_sd(w_pred);
  assign w_match     = (w_sd_rx[0] == w_sd_exp[0]);
  assign w_all_valid = sym_valid(io_rxData[11:9]) & sym_valid(io_rxData[8:6]) &
                       sym_valid(io_rxData[5:3])  & sym_valid(io_rxData[2:0]);
  assign w_all_pm2   = sym_is_pm2(io_rxData[11:9]) & sym_is_pm2(io_rxData[8:6]) &
                       sym_is_pm2(io_rxData[5:3])  & sym_is_pm2(io_rxData[2:0]);
  assign w_is_dlm1   = (io_rxData == SSD1);
  assign w_is_dlm2   = (io_rxData == SSD2);

  // Next-state, counter and output decode.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_miss_nx   = r_miss;
    w_byte_nx   = r_byte;
    w_dv_nx     = 1'b0;
    w_er_nx     = 1'b0;
    w_locked_nx = r_locked;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    if (io_rxValid) begin
      case (r_state)
        ST_UNLOCKED: begin
          w_load = 1'b1;
          if (r_cnt == LOAD_LAST) begin
            w_state_nx = ST_CHECK;
            w_cnt_nx   = 16'd0;
          end else begin
            w_cnt_nx = r_cnt + 16'd1;
          end
        end
        ST_CHECK: begin
          w_adv = 1'b1;
          // Lock is declared on the cycle after the last match.
          if (r_cnt == LOCK_CHECK_C) begin
            w_state_nx  = ST_IDLE;
            w_locked_nx = 1'b1;
            w_cnt_nx    = 16'd0;
            w_miss_nx   = 16'd0;
          end else if (w_match) begin
            w_cnt_nx = r_cnt + 16'd1;
          end else begin
            w_state_nx = ST_UNLOCKED;
            w_cnt_nx   = 16'd0;
          end
        end
        ST_IDLE: begin
          w_adv = 1'b1;
          if (w_is_dlm1) begin
            w_state_nx = ST_SSD2;
            w_miss_nx  = 16'd0;
          end else if (w_match) begin
            w_miss_nx = 16'd0;
          end else if (r_miss == MISS_LAST) begin
            w_state_nx  = ST_UNLOCKED;
            w_locked_nx = 1'b0;
            w_miss_nx   = 16'd0;
            w_cnt_nx    = 16'd0;
          end else begin
            w_miss_nx = r_miss + 16'd1;
          end
        end
        ST_SSD2: begin
          w_adv = 1'b1;
          if (w_is_dlm2) begin
            w_state_nx = ST_DATA;
          end else begin
            w_er_nx    = 1'b1;
            w_state_nx = ST_IDLE;
          end
        end
        ST_DATA: begin
          w_adv = 1'b1;
          // All-+2 is ESD1 before it can count as a bad quartet.
          if (w_is_dlm1) begin
            w_state_nx = ST_ESD2;
          end else if (!w_all_valid || w_all_pm2) begin
            w_dv_nx   = 1'b1;
            w_er_nx   = 1'b1;
            w_byte_nx = 8'h00;
          end else begin
            w_dv_nx   = 1'b1;
            w_byte_nx = w_sd_rx ^ w_sd_exp;
          end
        end
        ST_ESD2: begin
          w_adv      = 1'b1;
          w_state_nx = ST_IDLE;
          if (w_is_dlm2) begin
            w_er_nx = 1'b0;
          end else begin
            w_er_nx = 1'b1;
          end
        end
        default: begin
          w_state_nx  = ST_UNLOCKED;
          w_cnt_nx    = 16'd0;
          w_miss_nx   = 16'd0;
          w_locked_nx = 1'b0;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_UNLOCKED;
      r_cnt    <= 16'd0;
      r_miss   <= 16'd0;
      r_byte   <= 8'h00;
      r_dv     <= 1'b0;
      r_er     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_miss   <= w_miss_nx;
      r_byte   <= w_byte_nx;
      r_dv     <= w_dv_nx;
      r_er     <= w_er_nx;
      r_locked <= w_locked_nx;
    end
  end

  assign io_rxByte = r_byte;
  assign io_rxDv   = r_dv;
  assign io_rxEr   = r_er;
  assign io_locked = r_locked;

`ifdef PCS_RX_ERR_COUNT_EN
  logic [15:0] r_err_cnt;

  // Saturating error counter, updated in step with io_rxEr.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_cnt <= 16'd0;
    end else if (w_er_nx && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign io_errCount = r_err_cnt;
`endif

endmodule
